array_scheduler: RTL

Shares one heap-array store (per-array size table, freed-arrays stack, allocation counter, heap of `NArrays*NArea` words) between several requesters. It serializes four array operations: ALLOC, FREE, WRITE and COUNT_LESS. COUNT_LESS is sequenced as a one-element-per-cycle scan instead of a single combinational loop. The block sits between the instruction executors and heap memory, and is the only agent that mutates array state.

---
 rtl/array_scheduler_pkg.sv | 24 ++
 rtl/array_scheduler_rr_arbiter.sv | 24 ++
 rtl/array_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/array_scheduler_pkg.sv
// Shared types and width helpers for the array scheduler and its arbiter.
package array_scheduler_pkg;

  typedef enum logic [1:0] {
    OpAlloc     = 2'd0,
    OpFree      = 2'd1,
    OpWrite     = 2'd2,
    OpCountLess = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StResp
  } state_e;

  localparam int unsigned OpW = 2;

  // $clog2 that never yields a zero-width vector.
  function automatic int unsigned clog2_min1(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/array_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr.
module rr_arbiter #(
  parameter int unsigned NReq = 2,
  parameter int unsigned PtrW = 1
) (
  input  logic [NReq-1:0] req,
  input  logic [PtrW-1:0] ptr,
  output logic [NReq-1:0] gnt
);

  logic [PtrW-1:0] idx;

  always_comb begin
    gnt = '0;
    idx = '0;
    for (int unsigned k = 0; k < NReq; k++) begin
      idx = PtrW'((32'(ptr) + k) % NReq);
      if (gnt == '0 && req[idx]) begin
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/array_scheduler.sv
// Serializes ALLOC/FREE/WRITE/COUNT_LESS from several requesters onto one heap-array store.
module array_scheduler
  import array_scheduler_pkg::*;
#(
  parameter int unsigned MemoryElementWidth = 12,
  parameter int unsigned NArea              = 3,
  parameter int unsigned NArrays            = 4,
  parameter int unsigned NReq               = 2,
  localparam int unsigned AW  = clog2_min1(NArrays),
  localparam int unsigned IW  = clog2_min1(NArea),
  localparam int unsigned IdW = clog2_min1(NReq)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NReq-1:0]                req_valid,
  output logic [NReq-1:0]                req_ready,
  input  logic [OpW*NReq-1:0]            req_op,
  input  logic [AW*NReq-1:0]             req_array,
  input  logic [IW*NReq-1:0]             req_index,
  input  logic [MemoryElementWidth*NReq-1:0] req_value,
  output logic                           resp_valid,
  output logic [IdW-1:0]                 resp_id,
  output logic [MemoryElementWidth-1:0]  resp_result,
  output logic                           resp_err,
  output logic                           busy
);

  localparam int unsigned MW = MemoryElementWidth;
  localparam int unsigned CW = $clog2(NArrays + 1);
  localparam int unsigned SW = $clog2(NArea + 1);
  localparam int unsigned HW = clog2_min1(NArrays * NArea);

  state_e          state_q, state_d;
  logic [IdW-1:0]  ptr_q, id_q, gid;
  op_e             op_q, g_op;
  logic [AW-1:0]   arr_q, g_arr, alloc_arr, top_idx;
  logic [IW-1:0]   idx_q, g_idx, scan_q;
  logic [MW-1:0]   val_q, g_val, cnt_q;
  logic [NReq-1:0] gnt;
  logic [CW-1:0]   allocs_q, sp_q;
  logic [NArrays-1:0] allocated_q;
  logic [AW-1:0]   stack_q [NArrays];
  logic [SW-1:0]   size_q [NArrays];
  logic [MW-1:0]   heap_q [NArrays*NArea];
  logic [HW-1:0]   wr_addr, scan_addr;
  logic [SW-1:0]   idx_plus1;
  logic            accept, g_legal_cl, arr_ok, idx_ok, pop, alloc_new, hit;
  logic            do_alloc, do_free, do_write;

  rr_arbiter #(
    .NReq(NReq),
    .PtrW(IdW)
  ) u_arb (
    .req(req_valid),
    .ptr(ptr_q),
    .gnt(gnt)
  );

  always_comb begin
    gid   = '0;
    g_op  = OpAlloc;
    g_arr = '0;
    g_idx = '0;
    g_val = '0;
    for (int unsigned r = 0; r < NReq; r++) begin
      if (gnt[r]) begin
        gid   = IdW'(r);
        g_op  = op_e'(req_op[r*OpW +: OpW]);
        g_arr = req_array[r*AW +: AW];
        g_idx = req_index[r*IW +: IW];
        g_val = req_value[r*MW +: MW];
      end
    end
  end

  assign req_ready  = (state_q == StIdle) ? gnt : '0;
  assign accept     = (state_q == StIdle) && (|req_valid);
  assign busy       = (state_q != StIdle);
  assign resp_id    = id_q;
  assign g_legal_cl = (g_op == OpCountLess) && (32'(g_arr) < NArrays) && allocated_q[g_arr];

  // Pre-operation view of the store, used by the RESP decision and the update.
  assign arr_ok    = (32'(arr_q) < NArrays) && allocated_q[arr_q];
  assign idx_ok    = 32'(idx_q) < NArea;
  assign pop       = (sp_q != '0);
  assign alloc_new = !pop && (32'(allocs_q) < NArrays);
  assign top_idx   = AW'(sp_q - 1'b1);
  assign alloc_arr = pop ? stack_q[top_idx] : AW'(allocs_q);
  assign idx_plus1 = SW'(idx_q) + SW'(1);
  assign wr_addr   = HW'(arr_q) * HW'(NArea) + HW'(idx_q);
  assign scan_addr = HW'(arr_q) * HW'(NArea) + HW'(scan_q);
  assign hit       = (SW'(scan_q) < size_q[arr_q]) && (heap_q[scan_addr] < val_q);

  always_comb begin
    resp_valid  = (state_q == StResp);
    resp_result = '0;
    resp_err    = 1'b0;
    do_alloc    = 1'b0;
    do_free     = 1'b0;
    do_write    = 1'b0;
    if (state_q == StResp) begin
      unique case (op_q)
        OpAlloc: begin
          if (pop || alloc_new) begin
            do_alloc    = 1'b1;
            resp_result = MW'(alloc_arr);
          end else begin
            resp_err = 1'b1;
          end
        end
        OpFree:  if (arr_ok) do_free = 1'b1; else resp_err = 1'b1;
        OpWrite: if (arr_ok && idx_ok) do_write = 1'b1; else resp_err = 1'b1;
        OpCountLess: if (arr_ok) resp_result = cnt_q; else resp_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = g_legal_cl ? StScan : StResp;
      StScan:  if (scan_q == IW'(NArea - 1)) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      op_q    <= OpAlloc;
      arr_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      cnt_q   <= '0;
      scan_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q   <= gid;
        op_q   <= g_op;
        arr_q  <= g_arr;
        idx_q  <= g_idx;
        val_q  <= g_val;
        cnt_q  <= '0;
        scan_q <= '0;
        ptr_q  <= (gid == IdW'(NReq - 1)) ? '0 : gid + 1'b1;
      end
      if (state_q == StScan) begin
        scan_q <= scan_q + 1'b1;
        if (hit) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Stack slots are only meaningful below sp_q, so they need no reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      allocs_q    <= '0;
      sp_q        <= '0;
      allocated_q <= '0;
      for (int unsigned i = 0; i < NArrays; i++) size_q[i] <= '0;
    end else begin
      if (do_alloc) begin
        if (pop) sp_q <= sp_q - 1'b1;
        else     allocs_q <= allocs_q + 1'b1;
        allocated_q[alloc_arr] <= 1'b1;
        size_q[alloc_arr]      <= '0;
      end
      if (do_free) begin
        stack_q[AW'(sp_q)] <= arr_q;
        sp_q               <= sp_q + 1'b1;
        allocated_q[arr_q] <= 1'b0;
        size_q[arr_q]      <= '0;
      end
      if (do_write && (idx_plus1 > size_q[arr_q])) size_q[arr_q] <= idx_plus1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_write) heap_q[wr_addr] <= val_q;
  end

endmodule
